// File: rtl/cond_pkg.sv
// Shared types and constants for the conditional-execution stage.
package cond_pkg;

    typedef enum logic [3:0] {
        COND_EQ = 4'h0,
        COND_NE = 4'h1,
        COND_CS = 4'h2,
        COND_CC = 4'h3,
        COND_MI = 4'h4,
        COND_PL = 4'h5,
        COND_VS = 4'h6,
        COND_VC = 4'h7,
        COND_HI = 4'h8,
        COND_LS = 4'h9,
        COND_GE = 4'hA,
        COND_LT = 4'hB,
        COND_GT = 4'hC,
        COND_LE = 4'hD,
        COND_AL = 4'hE,
        COND_NV = 4'hF
    } cond_e;

    localparam int unsigned FLAG_N = 3;
    localparam int unsigned FLAG_Z = 2;
    localparam int unsigned FLAG_C = 1;
    localparam int unsigned FLAG_V = 0;

    typedef logic [1:0] flagw_t;

endpackage

// File: rtl/cond_logic_if.sv
// Decoder-to-conditional-logic bus: request strobes in, gated strobes and flags out.
interface cond_logic_if;
    import cond_pkg::*;

    logic [3:0] Cond;
    logic [3:0] ALUFlags;
    flagw_t     FlagW;
    logic       PCS;
    logic       RegW;
    logic       MemW;
    logic       NoWrite;
    logic       PCSrc;
    logic       RegWrite;
    logic       MemWrite;
    logic       CondEx;
    logic [3:0] Flags;

    modport master (
        output Cond, ALUFlags, FlagW, PCS, RegW, MemW, NoWrite,
        input  PCSrc, RegWrite, MemWrite, CondEx, Flags
    );

    modport slave (
        input  Cond, ALUFlags, FlagW, PCS, RegW, MemW, NoWrite,
        output PCSrc, RegWrite, MemWrite, CondEx, Flags
    );

endinterface

// File: rtl/cond_check.sv
// Combinational condition-code evaluator: (Cond, NZCV) -> pass/fail.
module cond_check
    import cond_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] flags,
    output logic       cond_ex
);

    logic n, z, c, v;

    always_comb begin
        n = flags[FLAG_N];
        z = flags[FLAG_Z];
        c = flags[FLAG_C];
        v = flags[FLAG_V];

        cond_ex = 1'b1;
        case (cond_e'(cond))
            COND_EQ: cond_ex = z;
            COND_NE: cond_ex = ~z;
            COND_CS: cond_ex = c;
            COND_CC: cond_ex = ~c;
            COND_MI: cond_ex = n;
            COND_PL: cond_ex = ~n;
            COND_VS: cond_ex = v;
            COND_VC: cond_ex = ~v;
            COND_HI: cond_ex = c & ~z;
            COND_LS: cond_ex = ~c | z;
            COND_GE: cond_ex = (n == v);
            COND_LT: cond_ex = (n != v);
            COND_GT: cond_ex = ~z & (n == v);
            COND_LE: cond_ex = z | (n != v);
            // NV is deliberately executed as always
            COND_AL, COND_NV: cond_ex = 1'b1;
            default: cond_ex = 1'b1;
        endcase
    end

endmodule

// File: rtl/cond_logic.sv
// Conditional-execution stage: owns the NZCV register and gates PCS/RegW/MemW
// by the condition evaluated against the registered (pre-update) flags.
module cond_logic
    import cond_pkg::*;
#(
    parameter logic [3:0] FLAG_RESET = 4'b0000
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    cond_logic_if.slave  bus
);

    logic [3:0] flags_q;
    logic [3:0] flags_d;
    logic       cond_ex;

    cond_check u_cond_check (
        .cond    (bus.Cond),
        .flags   (flags_q),
        .cond_ex (cond_ex)
    );

    // N/Z and C/V halves update independently, only when the instruction executes
    always_comb begin
        flags_d = flags_q;
        if (en && cond_ex) begin
            if (bus.FlagW[1]) begin
                flags_d[FLAG_N] = bus.ALUFlags[FLAG_N];
                flags_d[FLAG_Z] = bus.ALUFlags[FLAG_Z];
            end
            if (bus.FlagW[0]) begin
                flags_d[FLAG_C] = bus.ALUFlags[FLAG_C];
                flags_d[FLAG_V] = bus.ALUFlags[FLAG_V];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            flags_q <= FLAG_RESET;
        end else begin
            flags_q <= flags_d;
        end
    end

    always_comb begin
        bus.CondEx   = cond_ex;
        bus.Flags    = flags_q;
        bus.PCSrc    = rst_n & bus.PCS  & cond_ex;
        bus.RegWrite = rst_n & bus.RegW & cond_ex & ~bus.NoWrite;
        bus.MemWrite = rst_n & bus.MemW & cond_ex;
    end

endmodule

// File: doc/cond_logic.md
Name: cond_logic

Overview:
- Conditional-execution stage directly downstream of the main decoder and ALU decoder in the single-cycle ARM datapath.
- Holds the architectural NZCV flag register.
- Evaluates the instruction's 4-bit condition field against the current flags.
- Gates the decoder's PCS, RegW and MemW strobes, so an instruction whose condition fails changes no architectural state.

Parameters:
- FLAG_RESET, 4'b0000: NZCV value loaded on reset, bit order {N,Z,C,V}.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  synchronous reset, active-low.
- en  in  1  global advance enable; 0 = stall, flags hold.
- Cond  in  4  instruction bits [31:28].
- ALUFlags  in  4  {N,Z,C,V} produced by the ALU this cycle.
- FlagW  in  2  from ALU decoder; [1] = write N,Z; [0] = write C,V.
- PCS  in  1  PC-source request (branch, or write to R15).
- RegW  in  1  register-write request from main decoder.
- MemW  in  1  memory-write request from main decoder.
- NoWrite  in  1  compare-class op (CMP/CMN/TST/TEQ); suppresses register write.
- PCSrc  out  1  gated PC-source select.
- RegWrite  out  1  gated register-file write enable.
- MemWrite  out  1  gated data-memory write enable.
- CondEx  out  1  condition passed (combinational).
- Flags  out  4  current registered {N,Z,C,V}.

Behaviour:
- One clock domain. Reset is synchronous and active-low: on a rising clk edge with rst_n=0, Flags <= FLAG_RESET.
- Outputs while rst_n=0: PCSrc, RegWrite and MemWrite are forced to 0 combinationally. CondEx is still computed normally.
- Latency:
  - CondEx and the gated strobes are combinational from Cond, the registered Flags and the request inputs (0 cycles).
  - New flags become visible one cycle later.
- CondEx uses the registered (pre-update) flags only, never ALUFlags. Same-cycle S-instruction followed by a conditional instruction therefore sees the updated flags on the next cycle.
- Condition table (N,Z,C,V = registered flags):
  - 0000 EQ: Z
  - 0001 NE: ~Z
  - 0010 CS: C
  - 0011 CC: ~C
  - 0100 MI: N
  - 0101 PL: ~N
  - 0110 VS: V
  - 0111 VC: ~V
  - 1000 HI: C&~Z
  - 1001 LS: ~C|Z
  - 1010 GE: N==V
  - 1011 LT: N!=V
  - 1100 GT: ~Z&(N==V)
  - 1101 LE: Z|(N!=V)
  - 1110 AL: 1
  - 1111: treated as AL, CondEx = 1
- Flag update on rising edge when rst_n=1, en=1 and CondEx=1:
  - FlagW[1]=1: N,Z <= ALUFlags[3:2].
  - FlagW[0]=1: C,V <= ALUFlags[1:0].
  - The two halves are independent; any combination of FlagW is legal.
- A failed condition (CondEx=0) updates no flag, even with FlagW != 0.
- en=0: flags hold. Gated strobes are still driven from the current inputs; upstream is responsible for deasserting requests during stall.
- Gating:
  - PCSrc = PCS & CondEx
  - RegWrite = RegW & CondEx & ~NoWrite
  - MemWrite = MemW & CondEx
- NoWrite=1 with FlagW != 0 (CMP-type) updates flags and never asserts RegWrite.
- Reset asserted mid-operation overrides a pending flag write in the same edge; FLAG_RESET wins.
- No X propagation: every output is defined for all 2^4 Cond values.

Decomposition:
- Shared package cond_pkg:
  - cond_e enum for the 16 condition codes (EQ..AL, NV).
  - Flag index constants FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0.
  - flagw_t typedef for the 2-bit FlagW.
- One natural sub-module, cond_check: purely combinational (Cond, Flags) -> CondEx, implementing the table above. It is reused by any future pipelined variant.
- cond_logic owns the flag register and the gating.

Test Plan:
- Reset: rst_n=0 for 2 cycles with FLAG_RESET=0 -> Flags=0000; PCSrc=RegWrite=MemWrite=0 even with PCS=RegW=MemW=1, Cond=1110.
- Flag write split: Cond=1110, FlagW=10, ALUFlags=1111 -> next cycle Flags=1100. Then FlagW=01, ALUFlags=0011 -> Flags=1111.
- Condition sweep: for every Flags value (16, loaded via AL writes) × every Cond (16) -> CondEx matches the table; 256 checks against a bench model.
- Failed condition suppresses all effects: Flags=0000 (Z=0), Cond=0000 EQ, PCS=RegW=MemW=1, FlagW=11, ALUFlags=0100:
  - same cycle: PCSrc=RegWrite=MemWrite=0;
  - next cycle: Flags stays 0000.
- CMP path: Cond=1110, RegW=1, NoWrite=1, FlagW=11, ALUFlags=0110 -> RegWrite=0 and next Flags=0110. Following BEQ (Cond=0000, PCS=1) -> PCSrc=1.
- Stall and reset precedence:
  - en=0, FlagW=11, ALUFlags=1010 -> Flags unchanged.
  - rst_n=0 coinciding with en=1, FlagW=11 -> Flags=FLAG_RESET next cycle.
